// File: rtl/gobou_layer_seq_if.sv
// gobou_layer_seq_if: req/ack command bus between the layer sequencer and gobou_ctrl
// master (sequencer): drives req and the layer parameters, receives ack
// slave (gobou_ctrl): receives req and the layer parameters, drives ack
interface gobou_layer_seq_if #(
    parameter int IMGSIZE = 12,
    parameter int LWIDTH  = 10
) ();
    logic               req;
    logic               ack;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [IMGSIZE-1:0] input_addr;
    logic [IMGSIZE-1:0] output_addr;
    modport master (output req, total_in, total_out, input_addr, output_addr, input ack);
    modport slave  (input req, total_in, total_out, input_addr, output_addr, output ack);
endinterface

// File: rtl/gobou_layer_seq.sv
// gobou_layer_seq: walks a descriptor table, issuing one 4-phase req/ack command per layer
// Ports: clk, xrst (async active-low); start/abort/num_layers control the run;
// desc_* load the descriptor table while idle; cmd carries req/ack and the layer
// parameters; busy/done/layer_idx report progress.
module gobou_layer_seq #(
    parameter int IMGSIZE  = 12,
    parameter int LWIDTH   = 10,
    parameter int LAYERLOG = 3
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                start,
    input  logic                abort,
    input  logic [LAYERLOG:0]   num_layers,
    input  logic                desc_we,
    input  logic [LAYERLOG-1:0] desc_addr,
    input  logic [LWIDTH-1:0]   desc_total_in,
    input  logic [LWIDTH-1:0]   desc_total_out,
    input  logic [IMGSIZE-1:0]  desc_input_addr,
    input  logic [IMGSIZE-1:0]  desc_output_addr,
    gobou_layer_seq_if.master   cmd,
    output logic                busy,
    output logic                done,
    output logic [LAYERLOG-1:0] layer_idx
);
    localparam int MAXLAYER = 1 << LAYERLOG;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, REL, DONE} state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [LAYERLOG-1:0]  idx_q, idx_d;
    logic [LAYERLOG:0]    cnt_q, cnt_d, cnt_clamp, idx_next;
    logic [LWIDTH-1:0]    tin_q, tin_d, tout_q, tout_d;
    logic [IMGSIZE-1:0]   iaddr_q, iaddr_d, oaddr_q, oaddr_d;

    logic [LWIDTH-1:0]    tab_tin   [MAXLAYER];
    logic [LWIDTH-1:0]    tab_tout  [MAXLAYER];
    logic [IMGSIZE-1:0]   tab_iaddr [MAXLAYER];
    logic [IMGSIZE-1:0]   tab_oaddr [MAXLAYER];

    // Table is frozen while a sequence is running so the parameters stay coherent.
    always_ff @(posedge clk) begin
        if (desc_we && !busy_q) begin
            tab_tin[desc_addr]   <= desc_total_in;
            tab_tout[desc_addr]  <= desc_total_out;
            tab_iaddr[desc_addr] <= desc_input_addr;
            tab_oaddr[desc_addr] <= desc_output_addr;
        end
    end

    assign cnt_clamp = num_layers > (LAYERLOG+1)'(MAXLAYER) ? (LAYERLOG+1)'(MAXLAYER) : num_layers;
    assign idx_next  = {1'b0, idx_q} + (LAYERLOG+1)'(1);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tin_d   = tin_q;
        tout_d  = tout_q;
        iaddr_d = iaddr_q;
        oaddr_d = oaddr_q;
        case (state_q)
            IDLE: if (start) begin
                cnt_d = cnt_clamp;
                if (cnt_clamp == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                tin_d   = tab_tin[idx_q];
                tout_d  = tab_tout[idx_q];
                iaddr_d = tab_iaddr[idx_q];
                oaddr_d = tab_oaddr[idx_q];
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (cmd.ack) begin
                req_d   = 1'b0;
                state_d = REL;
            end
            REL: if (!cmd.ack) begin
                if (idx_next < cnt_q) begin
                    idx_d   = idx_next[LAYERLOG-1:0];
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything and suppresses the done pulse.
        if (abort) begin
            state_d = IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tin_q   <= '0;
            tout_q  <= '0;
            iaddr_q <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tin_q   <= tin_d;
            tout_q  <= tout_d;
            iaddr_q <= iaddr_d;
            oaddr_q <= oaddr_d;
        end
    end

    assign cmd.req         = req_q;
    assign cmd.total_in    = tin_q;
    assign cmd.total_out   = tout_q;
    assign cmd.input_addr  = iaddr_q;
    assign cmd.output_addr = oaddr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign layer_idx       = idx_q;
endmodule
